// File: rtl/usb_uart_pkg.sv
// Shared types for the USB UART transmit arbiter: FSM encoding and channel tag format.
package usb_uart_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_TAG  = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  localparam logic [3:0] TAG_PREFIX = 4'hA;

  // Tag byte announcing which requester owns the following burst.
  function automatic logic [7:0] make_tag(input logic [2:0] id);
    return {TAG_PREFIX, 1'b0, id};
  endfunction

endpackage

// File: rtl/usb_uart_tx_arbiter_if.sv
// Requester-side and UART-side byte streams plus status of the transmit arbiter.
interface usb_uart_tx_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
);
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [7:0]         uart_in_data;
  logic               uart_in_valid;
  logic               uart_in_ready;
  logic [IDW-1:0]     grant_id;
  logic               busy;
  logic               timeout_pulse;
  logic               burst_pulse;

  modport master (
    input  req_data, req_valid, req_last, uart_in_ready,
    output req_ready, uart_in_data, uart_in_valid,
    output grant_id, busy, timeout_pulse, burst_pulse
  );

  modport slave (
    output req_data, req_valid, req_last, uart_in_ready,
    input  req_ready, uart_in_data, uart_in_valid,
    input  grant_id, busy, timeout_pulse, burst_pulse
  );
endinterface

// File: rtl/usb_rr_picker.sv
// Combinational round-robin find-first: first set request after last_grant, with wrap.
module usb_rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   last_grant,
  output logic [IDW-1:0]   index,
  output logic             any
);

  logic [IDW-1:0] cand;

  // Scan offsets 1..N_REQ so the previous winner is considered last.
  always_comb begin
    index = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDW'((int'(last_grant) + k) % N_REQ);
      if (!any && req[cand]) begin
        any   = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/usb_uart_tx_arbiter.sv
// Shares the USB UART device-to-host byte stream among N_REQ requesters with
// round-robin message-locked grants, optional tag bytes, burst limit and idle timeout.
module usb_uart_tx_arbiter
  import usb_uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int IDW          = $clog2(N_REQ),
  parameter int TAG_EN       = 1,
  parameter int MAX_BURST    = 64,
  parameter int IDLE_TIMEOUT = 1024
) (
  input logic                   clk_48mhz,
  input logic                   reset_n,
  usb_uart_tx_arbiter_if.master bus
);

  arb_state_t     state, state_nxt;
  logic [IDW-1:0] grant_q, last_grant, pick_idx;
  logic           pick_any;
  logic [7:0]     byte_cnt;
  logic [15:0]    idle_cnt;
  logic [7:0]     tag_q;
  logic           timeout_q, burst_q;
  logic           take_grant, xfer, rel_timeout, rel_burst;
  logic           gnt_valid, gnt_last;
  logic [7:0]     req_bytes [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
    assign req_bytes[i] = bus.req_data[8*i +: 8];
  end

  usb_rr_picker #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_picker (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .index      (pick_idx),
    .any        (pick_any)
  );

  assign gnt_valid = bus.req_valid[grant_q];
  assign gnt_last  = bus.req_last[grant_q];

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) state <= ARB_IDLE;
    else          state <= state_nxt;
  end

  // DATA is a pure pass-through of the granted channel; a stall (valid without
  // ready) advances neither counter, only a cycle with valid low ages the grant.
  always_comb begin
    state_nxt         = state;
    take_grant        = 1'b0;
    xfer              = 1'b0;
    rel_timeout       = 1'b0;
    rel_burst         = 1'b0;
    bus.uart_in_valid = 1'b0;
    bus.uart_in_data  = '0;
    bus.req_ready     = '0;
    unique case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          take_grant = 1'b1;
          state_nxt  = (TAG_EN != 0) ? ARB_TAG : ARB_DATA;
        end
      end
      ARB_TAG: begin
        bus.uart_in_valid = 1'b1;
        bus.uart_in_data  = tag_q;
        if (bus.uart_in_ready) state_nxt = ARB_DATA;
      end
      ARB_DATA: begin
        bus.uart_in_valid      = gnt_valid;
        bus.uart_in_data       = req_bytes[grant_q];
        bus.req_ready[grant_q] = bus.uart_in_ready;
        xfer                   = gnt_valid && bus.uart_in_ready;
        if (xfer) begin
          if (gnt_last) begin
            state_nxt = ARB_IDLE;
          end else if (({1'b0, byte_cnt} + 9'd1) == 9'(MAX_BURST)) begin
            state_nxt = ARB_IDLE;
            rel_burst = 1'b1;
          end
        end else if (!gnt_valid && (idle_cnt == 16'(IDLE_TIMEOUT - 1))) begin
          state_nxt   = ARB_IDLE;
          rel_timeout = 1'b1;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      grant_q    <= '0;
      last_grant <= IDW'(N_REQ - 1);
      byte_cnt   <= '0;
      idle_cnt   <= '0;
      tag_q      <= '0;
      timeout_q  <= 1'b0;
      burst_q    <= 1'b0;
    end else begin
      timeout_q <= rel_timeout;
      burst_q   <= rel_burst;
      if (take_grant) begin
        grant_q    <= pick_idx;
        last_grant <= pick_idx;
        byte_cnt   <= '0;
        idle_cnt   <= '0;
        tag_q      <= make_tag(3'(pick_idx));
      end else if (state == ARB_DATA) begin
        if (xfer) begin
          byte_cnt <= byte_cnt + 8'd1;
          idle_cnt <= '0;
        end else if (!gnt_valid) begin
          idle_cnt <= idle_cnt + 16'd1;
        end
      end
    end
  end

  assign bus.grant_id      = grant_q;
  assign bus.busy          = (state != ARB_IDLE);
  assign bus.timeout_pulse = timeout_q;
  assign bus.burst_pulse   = burst_q;

endmodule

// File: doc/usb_uart_tx_arbiter.md
Name: usb_uart_tx_arbiter

Overview:
- Shares the single device-to-host byte pipeline (uart_in_data/valid/ready of the USB UART) between N_REQ independent byte-stream requesters.
- Round-robin grant with message locking; optional one-byte channel tag before each granted burst so host software can demultiplex.
- Idle timeout and max-burst limit keep one requester from stalling or starving the others.
- Sits between on-chip producers and the USB UART wrapper.

Parameters:
- N_REQ, 4: number of requesters, 2..8.
- IDW, $clog2(N_REQ): requester index width, derived.
- TAG_EN, 1: 1 = emit tag byte {4'hA, 1'b0, id[2:0]} (id zero-extended to 3 bits) before each burst.
- MAX_BURST, 64: payload bytes accepted per grant before forced release (1..255).
- IDLE_TIMEOUT, 1024: consecutive cycles with granted valid low before forced release (1..65535).

Ports:
- clk_48mhz  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_data  in  8*N_REQ  byte from requester i at [8i+7:8i].
- req_valid  in  N_REQ  byte valid per requester.
- req_last  in  N_REQ  marks final byte of a message; qualified by req_valid.
- req_ready  out  N_REQ  byte accepted per requester.
- uart_in_data  out  8  to USB UART.
- uart_in_valid  out  1  to USB UART.
- uart_in_ready  in  1  from USB UART.
- grant_id  out  IDW  currently/last granted requester.
- busy  out  1  high in TAG or DATA.
- timeout_pulse  out  1  one-cycle pulse on idle-timeout release.
- burst_pulse  out  1  one-cycle pulse on MAX_BURST release.

Behaviour:
- Reset state: IDLE. last_grant = N_REQ-1, so req0 has first priority. grant_id=0, busy=0, all pulses 0, req_ready=0, uart_in_valid=0, uart_in_data=0, counters 0.
- Handshake: a transfer occurs on a rising edge when valid && ready. A requester's valid must not depend on its ready.
- IDLE: uart_in_valid=0, req_ready=0.
  - Any req_valid high -> at the next edge, grant the first requester with valid set, scanning from (last_grant+1) mod N_REQ upward with wrap.
  - Latch grant_id and last_grant; clear byte_cnt and idle_cnt.
  - Go to TAG if TAG_EN, else DATA.
- TAG: uart_in_valid=1, uart_in_data=tag (registered). req_ready=0.
  - On uart_in_ready -> DATA.
- DATA: combinational pass-through of the granted channel only.
  - uart_in_data = req_data[grant], uart_in_valid = req_valid[grant], req_ready[grant] = uart_in_ready; all other req_ready = 0.
  - On a transfer: byte_cnt++, idle_cnt=0.
    - If req_last[grant] -> IDLE.
    - Else if byte_cnt+1 == MAX_BURST -> IDLE with burst_pulse.
  - Cycle with req_valid[grant]=0: idle_cnt++. When idle_cnt reaches IDLE_TIMEOUT-1 -> IDLE with timeout_pulse.
  - A cycle with valid=1 but ready=0 is a stall: idle_cnt holds, neither counter advances.
- Last byte and MAX_BURST on the same transfer: last wins, no burst_pulse.
- Minimum IDLE dwell is 1 cycle between grants (grant is registered). Latency from req_valid to tag on uart_in_valid is 1 cycle.
- A released requester with pending data competes again under round-robin. Its next burst gets a fresh tag; message continuity is the host's job.
- A requester dropping valid mid-message is legal. The grant is held until last, MAX_BURST or timeout.
- busy=1 in TAG and DATA. grant_id holds its value through IDLE.
- Reset assertion mid-burst: everything returns to reset state asynchronously. Any in-flight byte is abandoned with no ready pulse after reset.
- Counter widths: byte_cnt 8 bits, idle_cnt 16 bits; neither wraps, because release occurs first.

Decomposition:
- Shared package usb_uart_pkg: state encoding (ARB_IDLE, ARB_TAG, ARB_DATA), TAG_PREFIX = 4'hA.
- One natural sub-module: usb_rr_picker (combinational round-robin find-first from start index; inputs req vector and last_grant, outputs index and any).

Test Plan:
- Single requester: req1 sends 3 bytes 0x11,0x22,0x33 with last on 0x33, ready=1 -> output 0xA1,0x11,0x22,0x33, then IDLE; busy falls the cycle after 0x33.
- Round-robin: all 4 valid, each sending 1-byte messages -> tag order A0,A1,A2,A3,A0; no requester granted twice in a row while others wait.
- Backpressure: uart_in_ready toggles 1/0 during a 5-byte burst -> exactly 5 payload bytes, in order, no duplicates; req_ready mirrors uart_in_ready only on the granted channel.
- MAX_BURST=4, req0 streams 10 bytes without last, req2 pending -> A0 + 4 bytes, burst_pulse, A2 burst, then A0 resumes with byte 5.
- IDLE_TIMEOUT=8: req3 sends 1 byte then holds valid low -> timeout_pulse exactly 8 cycles after the last transfer; req0 granted next.
- Reset_n asserted during a stalled DATA cycle -> uart_in_valid=0 and req_ready=0 immediately; after release, first grant goes to req0.
